vout_pulsegen: RTL and testbench

Command-driven UP/DOWN pulse-train generator: the transmit-side counterpart of the pulse-counter input, driving the same two-line UP/DOWN count interface toward external hardware or a remote counter. A signed 16-bit request is converted into |count| clean pulses on UP (positive) or DOWN (negative), with programmable high and low times. It sits between the host register interface and output pins, with a load/busy/done handshake so firmware can queue moves without dropping pulses.

---
 rtl/vout_pulsegen_if.sv | 22 ++
 rtl/vout_pulsegen.sv | 101 ++++++++++
 tb/tb_vout_pulsegen.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vout_pulsegen_if.sv
// Host-side command/status bundle of the UP/DOWN pulse-train generator.
// The host drives the command (master); the generator answers with pins and status (slave).
interface vout_pulsegen_if;
    logic        load;
    logic [15:0] count;
    logic        abort;
    logic        UP;
    logic        DOWN;
    logic        busy;
    logic        done;
    logic [15:0] remaining;

    modport master (
        output load, count, abort,
        input  UP, DOWN, busy, done, remaining
    );

    modport slave (
        input  load, count, abort,
        output UP, DOWN, busy, done, remaining
    );
endinterface

// File: rtl/vout_pulsegen.sv
// Converts a signed pulse request into |count| UP or DOWN pulses of fixed high/low time,
// with a load/busy/done handshake and graceful abort that never truncates a pulse.
module vout_pulsegen #(
    parameter int PULSE_WIDTH = 4,
    parameter int PULSE_GAP   = 4
) (
    input  logic            clk,
    input  logic            RESET,
    vout_pulsegen_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW, FIN} state_t;

    localparam int MAX_PHASE = (PULSE_WIDTH > PULSE_GAP) ? PULSE_WIDTH : PULSE_GAP;
    localparam int TW        = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;
    localparam logic [TW-1:0] HIGH_LAST = TW'(PULSE_WIDTH - 1);
    localparam logic [TW-1:0] LOW_LAST  = TW'(PULSE_GAP - 1);

    state_t        state_reg, state_next;
    logic [TW-1:0] phase_reg, phase_next;
    logic [15:0]   remaining_reg, remaining_next;
    logic          dir_reg, dir_next;
    logic          abort_reg, abort_next;
    logic          up_reg, down_reg, busy_reg, done_reg;
    logic [15:0]   magnitude;
    logic          stop_now;

    // Two's-complement absolute value; -32768 maps cleanly onto 32768 as unsigned.
    assign magnitude = bus.count[15] ? (~bus.count + 16'd1) : bus.count;
    assign stop_now  = abort_reg | bus.abort;

    always_comb begin
        state_next     = state_reg;
        phase_next     = phase_reg;
        remaining_next = remaining_reg;
        dir_next       = dir_reg;
        abort_next     = abort_reg;
        unique case (state_reg)
            IDLE, FIN: begin
                if (bus.load) begin
                    dir_next       = bus.count[15];
                    remaining_next = magnitude;
                    abort_next     = 1'b0;
                    phase_next     = '0;
                    state_next     = (magnitude == 16'd0) ? FIN : HIGH;
                end else begin
                    state_next = IDLE;
                end
            end
            HIGH: begin
                if (bus.abort) abort_next = 1'b1;
                if (phase_reg == HIGH_LAST) begin
                    phase_next     = '0;
                    remaining_next = remaining_reg - 16'd1;
                    state_next     = LOW;
                end else begin
                    phase_next = phase_reg + 1'b1;
                end
            end
            LOW: begin
                if (bus.abort) abort_next = 1'b1;
                if (phase_reg == LOW_LAST) begin
                    phase_next = '0;
                    state_next = (remaining_reg != 16'd0 && !stop_now) ? HIGH : FIN;
                end else begin
                    phase_next = phase_reg + 1'b1;
                end
            end
        endcase
    end

    // Outputs are decoded from the next state so every pin comes straight off a flop.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_reg     <= IDLE;
            phase_reg     <= '0;
            remaining_reg <= 16'd0;
            dir_reg       <= 1'b0;
            abort_reg     <= 1'b0;
            up_reg        <= 1'b0;
            down_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            phase_reg     <= phase_next;
            remaining_reg <= remaining_next;
            dir_reg       <= dir_next;
            abort_reg     <= abort_next;
            up_reg        <= (state_next == HIGH) && !dir_next;
            down_reg      <= (state_next == HIGH) &&  dir_next;
            busy_reg      <= (state_next == HIGH) || (state_next == LOW);
            done_reg      <= (state_next == FIN);
        end
    end

    assign bus.UP        = up_reg;
    assign bus.DOWN      = down_reg;
    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.remaining = remaining_reg;
endmodule

// File: tb/tb_vout_pulsegen.sv
// Randomized scoreboard bench for vout_pulsegen: commands push expected pulses/done events,
// an independent monitor measures the pins and pops/compares.
module tb_vout_pulsegen;
    localparam int W = 4;
    localparam int G = 4;
    localparam int P = W + G;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1;
    vout_pulsegen_if bus0 ();
    vout_pulsegen_if bus1 ();

    vout_pulsegen #(.PULSE_WIDTH(W), .PULSE_GAP(G)) dut0 (.clk(clk), .RESET(rst0), .bus(bus0));
    vout_pulsegen #(.PULSE_WIDTH(1), .PULSE_GAP(1)) dut1 (.clk(clk), .RESET(rst1), .bus(bus1));

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit is_done;
        bit dir;
        int rem;
        int busy_cycles;
    } exp_t;
    exp_t sb[$];

    bit mon_en   = 0;
    bit big_done = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: what the host should see for one command.
    task automatic push_model(input int c, input int abort_k);
        int mag;
        int sent;
        bit dir;
        exp_t e;
        mag  = (c < 0) ? -c : c;
        dir  = (c < 0);
        sent = (abort_k > 0 && abort_k < mag) ? abort_k : mag;
        for (int i = 0; i < sent; i++) begin
            e = '{0, dir, mag - i, 0};
            sb.push_back(e);
        end
        e = '{1, 0, mag - sent, sent * P};
        sb.push_back(e);
    endtask

    // Monitor
    int cyc = 0;
    int hi_cnt, busy_cnt, last_rise, rem_at_rise;
    bit prev_line, dir_seen, line;
    exp_t me;

    always @(negedge clk) begin
        if (!mon_en) begin
            hi_cnt = 0; busy_cnt = 0; last_rise = -1; prev_line = 0; rem_at_rise = 0; dir_seen = 0;
        end else begin
            cyc++;
            checks++;
            if (bus0.UP && bus0.DOWN) begin
                errors++;
                $display("FAIL exclusive: got UP=1 DOWN=1 expected at most one high");
            end
            line = bus0.UP | bus0.DOWN;
            if (line && !prev_line) begin
                rem_at_rise = int'(bus0.remaining);
                dir_seen    = bus0.DOWN;
                if (last_rise >= 0) check("period", cyc - last_rise, P);
                last_rise = cyc;
                hi_cnt    = 0;
            end
            if (line) hi_cnt++;
            if (!line && prev_line) begin
                if (sb.size() == 0) check("unexpected_pulse", 1, 0);
                else begin
                    me = sb.pop_front();
                    $display("pulse dir=%0d width=%0d rem=%0d (exp dir=%0d rem=%0d)",
                             dir_seen, hi_cnt, rem_at_rise, me.dir, me.rem);
                    check("evt_kind_pulse", me.is_done, 0);
                    check("pulse_dir", dir_seen, me.dir);
                    check("pulse_width", hi_cnt, W);
                    check("pulse_rem", rem_at_rise, me.rem);
                end
            end
            if (bus0.busy) busy_cnt++;
            if (bus0.done) begin
                if (sb.size() == 0) check("unexpected_done", 1, 0);
                else begin
                    me = sb.pop_front();
                    $display("done rem=%0d busy_cycles=%0d (exp rem=%0d busy=%0d)",
                             bus0.remaining, busy_cnt, me.rem, me.busy_cycles);
                    check("evt_kind_done", me.is_done, 1);
                    check("done_rem", bus0.remaining, me.rem);
                    check("busy_cycles", busy_cnt, me.busy_cycles);
                    check("busy_at_done", bus0.busy, 0);
                end
                busy_cnt  = 0;
                last_rise = -1;
            end
            prev_line = line;
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus0.abort = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        bus0.abort = 0;
    endtask

    // Issue one command; returns at the negedge where done is visible.
    task automatic run_cmd(input int c, input int abort_k, input bit ign);
        int mag;
        int rises;
        bit prev;
        bit got_done;
        mag = (c < 0) ? -c : c;
        push_model(c, abort_k);
        bus0.load  = 1;
        bus0.count = 16'(c);
        @(negedge clk);
        bus0.load = 0;
        rises = 0; prev = 0; got_done = 0;
        if (mag == 0) begin
            check("zero_done", bus0.done, 1);
            check("zero_busy", bus0.busy, 0);
        end else begin
            check("first_pulse", (c < 0) ? bus0.DOWN : bus0.UP, 1);
            check("first_busy", bus0.busy, 1);
        end
        for (int t = 0; t < mag * P + 20; t++) begin
            if (bus0.done) begin
                got_done = 1;
                break;
            end
            bus0.abort = 0;
            if (ign && t == 1) begin
                bus0.load  = 1;
                bus0.count = 16'($urandom);
            end else begin
                bus0.load = 0;
            end
            if ((bus0.UP | bus0.DOWN) && !prev) begin
                rises++;
                if (abort_k > 0 && rises == abort_k) bus0.abort = 1;
            end
            prev = bus0.UP | bus0.DOWN;
            @(negedge clk);
        end
        bus0.load  = 0;
        bus0.abort = 0;
        if (!got_done) begin
            check("done_timeout", 0, 1);
            mon_en = 0;
            rst0   = 1;
            @(negedge clk);
            rst0 = 0;
            sb.delete();
            @(negedge clk);
            mon_en = 1;
        end
    endtask

    // Main stimulus on the default-timing instance
    int rc, rmag, rab;
    bit rign;
    initial begin
        rst0 = 1; bus0.load = 0; bus0.count = 0; bus0.abort = 0;
        repeat (3) @(negedge clk);
        rst0 = 0;
        @(negedge clk);
        // Asynchronous reset in the middle of a pulse
        bus0.load = 1; bus0.count = 16'd3;
        @(negedge clk);
        bus0.load = 0;
        @(negedge clk);
        check("pre_reset_up", bus0.UP, 1);
        #2 rst0 = 1;
        #1;
        check("rst_up", bus0.UP, 0);
        check("rst_down", bus0.DOWN, 0);
        check("rst_busy", bus0.busy, 0);
        check("rst_done", bus0.done, 0);
        check("rst_remaining", bus0.remaining, 0);
        @(negedge clk);
        rst0 = 0;
        mon_en = 1;
        @(negedge clk);

        run_cmd(3, 0, 0);   idle(3);
        run_cmd(-2, 0, 0);  idle(2);
        run_cmd(0, 0, 0);   idle(2);
        run_cmd(2, 0, 1);   idle(2);
        run_cmd(10, 3, 0);  idle(2);
        run_cmd(2, 0, 0);
        run_cmd(-1, 0, 0);  idle(3);

        for (int i = 0; i < 40; i++) begin
            rc   = int'($urandom_range(0, 12)) - 6;
            rmag = (rc < 0) ? -rc : rc;
            rab  = (rmag > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, rmag)) : 0;
            rign = (rmag > 0) && ($urandom_range(0, 1) == 1);
            run_cmd(rc, rab, rign);
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 4)));
        end
        idle(4);

        wait (big_done);
        check("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Extreme negative request on a 1/1-cycle instance, run alongside the main stimulus
    int downs = 0, ups = 0, bcyc = 0, dones = 0;
    bit bprev = 0, bfin = 0;
    initial begin
        rst1 = 1; bus1.load = 0; bus1.count = 0; bus1.abort = 0;
        repeat (2) @(negedge clk);
        rst1 = 0;
        @(negedge clk);
        bus1.load = 1; bus1.count = 16'h8000;
        @(negedge clk);
        bus1.load = 0;
        check("big_rem_start", bus1.remaining, 32768);
        for (int t = 0; t < 70000 && !bfin; t++) begin
            if (bus1.DOWN && !bprev) downs++;
            if (bus1.UP) ups++;
            if (bus1.busy) bcyc++;
            if (bus1.done) begin
                dones++;
                bfin = 1;
            end
            bprev = bus1.DOWN;
            if (!bfin) @(negedge clk);
        end
        check("big_rem_end", bus1.remaining, 0);
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            if (bus1.done) dones++;
        end
        $display("big train downs=%0d ups=%0d busy=%0d dones=%0d", downs, ups, bcyc, dones);
        check("big_down_pulses", downs, 32768);
        check("big_up_pulses", ups, 0);
        check("big_busy_cycles", bcyc, 65536);
        check("big_done_count", dones, 1);
        big_done = 1;
    end
endmodule
